// File: rtl/lfsr_parity_decoder.sv
// Receive-side stream decryptor: regenerates the LFSR keystream to recover 7-bit
// plaintext from ciphertext bytes and flags/counts even-parity errors per byte.
module lfsr_parity_decoder #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       taps,
    input  logic [6:0]       seed,
    input  logic [LEN_W-1:0] length,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_err,
    output logic [LEN_W-1:0] err_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [6:0]       lfsr_reg;
    logic [6:0]       taps_reg;
    logic [LEN_W-1:0] remaining_reg;
    logic             out_valid_reg;
    logic [7:0]       out_data_reg;
    logic             out_err_reg;
    logic [LEN_W-1:0] err_count_reg;

    logic             accept;
    logic             consume;
    logic             byte_err;
    logic             lfsr_fb;
    logic [LEN_W-1:0] err_count_next;

    // One-deep output register: a slot frees up in the same cycle it is consumed.
    assign in_ready = (state_reg == RUN) && (remaining_reg != '0)
                      && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_reg && out_ready;
    assign byte_err = ^in_data;
    assign lfsr_fb  = ^(taps_reg & lfsr_reg);

    always_comb begin
        err_count_next = err_count_reg;
        if (byte_err && (err_count_reg != '1))
            err_count_next = err_count_reg + LEN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lfsr_reg      <= '0;
            taps_reg      <= '0;
            remaining_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_err_reg   <= 1'b0;
            err_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        lfsr_reg      <= seed;
                        taps_reg      <= taps;
                        remaining_reg <= length;
                        err_count_reg <= '0;
                        state_reg     <= (length != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (accept) begin
                        out_data_reg  <= {1'b0, in_data[6:0] ^ lfsr_reg};
                        out_err_reg   <= byte_err;
                        out_valid_reg <= 1'b1;
                        lfsr_reg      <= {lfsr_reg[5:0], lfsr_fb};
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        err_count_reg <= err_count_next;
                    end else if (consume) begin
                        out_valid_reg <= 1'b0;
                    end
                    // Done only once the last decoded byte has left the output register.
                    if ((remaining_reg == '0) && (!out_valid_reg || out_ready))
                        state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_err   = out_err_reg;
    assign err_count = err_count_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_lfsr_parity_decoder.sv
// Directed bench for lfsr_parity_decoder: stimulus pushes expected {data,err} into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_lfsr_parity_decoder;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [6:0]       taps;
    logic [6:0]       seed;
    logic [LEN_W-1:0] length;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_err;
    logic [LEN_W-1:0] err_count;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    lfsr_parity_decoder #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .taps(taps), .seed(seed),
        .length(length), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .err_count(err_count),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got data=%0h err=%0b expected nothing", out_data, out_err);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({out_data, out_err} !== e) begin
                    errors++;
                    $display("FAIL out_byte: got data=%0h err=%0b expected data=%0h err=%0b",
                             out_data, out_err, e[8:1], e[0]);
                end else begin
                    $display("out byte data=%0h err=%0b ok", out_data, out_err);
                end
            end
        end
    end

    task automatic do_start(input logic [6:0] s, input logic [6:0] t, input logic [LEN_W-1:0] l);
        start = 1'b1; seed = s; taps = t; length = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] exp_data, input logic exp_err);
        int n;
        exp_q.push_back({exp_data, exp_err});
        in_valid = 1'b1; in_data = b; n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_done(input string name, input logic [LEN_W-1:0] exp_errs);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, {31'd0, done}, 32'd1);
        chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        chk({name, "_errcount"}, {24'd0, err_count}, {24'd0, exp_errs});
        chk({name, "_queue_drained"}, exp_q.size(), 32'd0);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({name, "_idle_after_done"}, {31'd0, busy}, 32'd0);
        chk({name, "_errcount_hold"}, {24'd0, err_count}, {24'd0, exp_errs});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; taps = '0; seed = '0; length = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy_done_inready", {29'd0, busy, done, in_ready}, 32'd0);
        chk("rst_errcount", {24'd0, err_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two good bytes, keystream 01,02.
        $display("txn: basic length=2");
        do_start(7'h01, 7'h60, 8'd2);
        send(8'hC0, 8'h41, 1'b0);
        send(8'hC0, 8'h42, 1'b0);
        expect_done("basic", 8'd0);

        // First byte has odd parity.
        $display("txn: parity error");
        do_start(7'h01, 7'h60, 8'd2);
        send(8'h40, 8'h41, 1'b1);
        send(8'hC0, 8'h42, 1'b0);
        expect_done("parity", 8'd1);

        // Backpressure: output held while downstream stalls.
        $display("txn: backpressure length=3");
        out_ready = 1'b0;
        do_start(7'h01, 7'h60, 8'd3);
        send(8'hC0, 8'h41, 1'b0);
        exp_q.push_back({8'h42, 1'b0});
        in_valid = 1'b1; in_data = 8'hC0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_data", {24'd0, out_data}, 32'h41);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        void'(exp_q.pop_back());
        send(8'hC0, 8'h42, 1'b0);
        send(8'hC0, 8'h44, 1'b0);
        expect_done("stall", 8'd0);

        // Empty message goes straight to DONE.
        $display("txn: length=0");
        do_start(7'h01, 7'h60, 8'd0);
        chk("len0_busy", {31'd0, busy}, 32'd1);
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("len0_idle", {30'd0, busy, done}, 32'd0);
        chk("len0_in_ready_after", {31'd0, in_ready}, 32'd0);

        // Zero seed: data passes through.
        $display("txn: seed=0");
        do_start(7'h00, 7'h60, 8'd1);
        send(8'hC5, 8'h45, 1'b0);
        expect_done("seed0", 8'd0);

        // Start during RUN must not reload the keystream.
        $display("txn: ignored restart");
        do_start(7'h01, 7'h60, 8'd3);
        send(8'hC0, 8'h41, 1'b0);
        do_start(7'h55, 7'h11, 8'd7);
        send(8'hC0, 8'h42, 1'b0);
        send(8'hC0, 8'h44, 1'b0);
        expect_done("restart", 8'd0);

        // Async reset mid-message, then a clean message from Seed.
        $display("txn: reset mid-message");
        out_ready = 1'b0;
        do_start(7'h01, 7'h60, 8'd5);
        in_valid = 1'b1; in_data = 8'h40;
        @(posedge clk); #1;
        in_data = 8'hC0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out_data", {24'd0, out_data}, 32'd0);
        chk("abort_out_err", {31'd0, out_err}, 32'd0);
        chk("abort_errcount", {24'd0, err_count}, 32'd0);
        chk("abort_busy_done_inready", {29'd0, busy, done, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("abort_still_idle", {30'd0, busy, done}, 32'd0);
        do_start(7'h01, 7'h60, 8'd2);
        send(8'hC0, 8'h41, 1'b0);
        send(8'hC0, 8'h42, 1'b0);
        expect_done("after_reset", 8'd0);

        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
